cnn_layer_accel_opcode_dispatcher: RTL and testbench

- Initiator side of the layer-engine opcode handshake (opcode / opcode_valid / opcode_accept / opcode_complete).
- Buffers opcodes pushed by the host/config path in a small FIFO and issues them to one layer engine, e.g. the convolver.
- At most one opcode is outstanding at a time.
- Tracks issue and completion counts and flags protocol violations and hangs.

---
 rtl/cnn_layer_accel_pkg.sv | 14 +
 rtl/cnn_layer_accel_sync_fifo.sv | 54 +++++
 rtl/cnn_layer_accel_opcode_dispatcher.sv | 143 ++++++++++++++
 tb/tb_cnn_layer_accel_opcode_dispatcher.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_layer_accel_pkg.sv
// Shared definitions for the CNN layer accelerator: opcode handshake width and
// the dispatcher FSM state encodings.
package cnn_layer_accel_pkg;

  localparam int unsigned C_OPCODE_WIDTH = 64;

  // One-hot so each state decodes from a single flop.
  typedef enum logic [2:0] {
    ST_IDLE          = 3'b001,
    ST_ISSUE         = 3'b010,
    ST_WAIT_COMPLETE = 3'b100
  } disp_state_t;

endpackage

// File: rtl/cnn_layer_accel_sync_fifo.sv
// Generic synchronous FIFO with a registered write-ready; pointers carry an
// extra MSB to tell full from empty.
module cnn_layer_accel_sync_fifo #(
  parameter int unsigned C_WIDTH = 8,
  parameter int unsigned C_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [C_WIDTH-1:0] wr_data,
  input  logic               wr_valid,
  output logic               wr_ready,
  output logic [C_WIDTH-1:0] rd_data,
  input  logic               rd_en,
  output logic               empty
);

  localparam int unsigned AW = $clog2(C_DEPTH);

  logic [C_WIDTH-1:0] mem [C_DEPTH];
  logic [AW:0]        wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
  logic               ready_q, full_d, push, pop;

  assign push     = wr_valid && ready_q;
  assign pop      = rd_en && !empty;
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign wr_ready = ready_q;
  assign rd_data  = mem[rd_ptr_q[AW-1:0]];

  // Ready reflects the post-update fill level, so a full FIFO refuses a push
  // even in the cycle that frees an entry.
  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
    full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
               (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ready_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ready_q  <= !full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/cnn_layer_accel_opcode_dispatcher.sv
// Buffers host opcodes and issues them one at a time to a layer engine over the
// opcode/accept/complete handshake, with counters and sticky error flags.
module cnn_layer_accel_opcode_dispatcher #(
  parameter int unsigned C_OPCODE_WIDTH   = cnn_layer_accel_pkg::C_OPCODE_WIDTH,
  parameter int unsigned C_FIFO_DEPTH     = 8,
  parameter int unsigned C_TIMEOUT_CYCLES = 0,
  parameter int unsigned C_COUNT_WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [C_OPCODE_WIDTH-1:0] cmd_data,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  output logic [C_OPCODE_WIDTH-1:0] opcode,
  output logic                      opcode_valid,
  input  logic                      opcode_accept,
  input  logic                      opcode_complete,
  output logic                      busy,
  output logic [C_COUNT_WIDTH-1:0]  issued_count,
  output logic [C_COUNT_WIDTH-1:0]  completed_count,
  output logic                      err_spurious,
  output logic                      err_timeout,
  input  logic                      clear_errors
);

  import cnn_layer_accel_pkg::*;

  localparam int unsigned TW = (C_TIMEOUT_CYCLES > 0) ? $clog2(C_TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(C_TIMEOUT_CYCLES);

  disp_state_t               state_q, state_d;
  logic [C_OPCODE_WIDTH-1:0] fifo_head, opcode_q;
  logic                      fifo_empty, fifo_pop, valid_q;
  logic [C_COUNT_WIDTH-1:0]  issued_q, completed_q;
  logic                      err_sp_q, err_to_q;
  logic [TW-1:0]             timer_q;
  logic                      ev_accept, ev_complete, ev_timeout, ev_spurious;

  cnn_layer_accel_sync_fifo #(
    .C_WIDTH (C_OPCODE_WIDTH),
    .C_DEPTH (C_FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (cmd_data),
    .wr_valid (cmd_valid),
    .wr_ready (cmd_ready),
    .rd_data  (fifo_head),
    .rd_en    (fifo_pop),
    .empty    (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    fifo_pop    = 1'b0;
    ev_accept   = 1'b0;
    ev_complete = 1'b0;
    ev_timeout  = 1'b0;
    ev_spurious = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (opcode_accept || opcode_complete) ev_spurious = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (opcode_accept) begin
          ev_accept = 1'b1;
          if (opcode_complete) begin
            ev_complete = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            state_d = ST_WAIT_COMPLETE;
          end
        end else if (opcode_complete) begin
          ev_spurious = 1'b1;
        end
      end
      ST_WAIT_COMPLETE: begin
        if (opcode_accept) ev_spurious = 1'b1;
        if (opcode_complete) begin
          ev_complete = 1'b1;
          state_d     = ST_IDLE;
        end else if ((C_TIMEOUT_CYCLES != 0) && (timer_q == TIMER_MAX)) begin
          ev_timeout = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Timer holds the number of cycles already spent waiting, so it is loaded
  // with 1 on accept and the timeout fires on the C_TIMEOUT_CYCLES-th edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode_q    <= '0;
      valid_q     <= 1'b0;
      issued_q    <= '0;
      completed_q <= '0;
      timer_q     <= '0;
      err_sp_q    <= 1'b0;
      err_to_q    <= 1'b0;
    end else begin
      if (fifo_pop) begin
        opcode_q <= fifo_head;
        valid_q  <= 1'b1;
      end
      if (ev_accept) begin
        valid_q  <= 1'b0;
        issued_q <= issued_q + 1'b1;
        timer_q  <= TW'(1);
      end else if (state_q == ST_WAIT_COMPLETE && C_TIMEOUT_CYCLES != 0) begin
        timer_q <= timer_q + 1'b1;
      end
      if (ev_complete) completed_q <= completed_q + 1'b1;
      if (ev_complete || ev_timeout) opcode_q <= '0;
      if (clear_errors) begin
        err_sp_q <= 1'b0;
        err_to_q <= 1'b0;
      end else begin
        if (ev_spurious) err_sp_q <= 1'b1;
        if (ev_timeout)  err_to_q <= 1'b1;
      end
    end
  end

  assign opcode          = opcode_q;
  assign opcode_valid    = valid_q;
  assign busy            = !fifo_empty || (state_q != ST_IDLE);
  assign issued_count    = issued_q;
  assign completed_count = completed_q;
  assign err_spurious    = err_sp_q;
  assign err_timeout     = err_to_q;

endmodule

// File: tb/tb_cnn_layer_accel_opcode_dispatcher.sv
// Directed bench for the opcode dispatcher: single issue, ordering, FIFO full,
// stall, protocol errors, timeout and asynchronous reset.
module tb_cnn_layer_accel_opcode_dispatcher;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [63:0] opcode;
  logic        opcode_valid;
  logic        opcode_accept;
  logic        opcode_complete;
  logic        busy;
  logic [15:0] issued_count;
  logic [15:0] completed_count;
  logic        err_spurious;
  logic        err_timeout;
  logic        clear_errors;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cnn_layer_accel_opcode_dispatcher #(
    .C_OPCODE_WIDTH   (64),
    .C_FIFO_DEPTH     (8),
    .C_TIMEOUT_CYCLES (20),
    .C_COUNT_WIDTH    (16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cmd_data        (cmd_data),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .opcode          (opcode),
    .opcode_valid    (opcode_valid),
    .opcode_accept   (opcode_accept),
    .opcode_complete (opcode_complete),
    .busy            (busy),
    .issued_count    (issued_count),
    .completed_count (completed_count),
    .err_spurious    (err_spurious),
    .err_timeout     (err_timeout),
    .clear_errors    (clear_errors)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [63:0] d);
    int unsigned n = 0;
    cmd_data  = d;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 200) begin
      tick();
      n++;
    end
    chk("push_ready", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_valid(input logic [63:0] exp_op);
    int unsigned n = 0;
    while (!opcode_valid && n < 200) begin
      tick();
      n++;
    end
    chk("wait_valid", 64'(opcode_valid), 64'd1);
    chk("issue_order", opcode, exp_op);
  endtask

  task automatic accept();
    opcode_accept = 1'b1;
    tick();
    opcode_accept = 1'b0;
  endtask

  task automatic complete();
    opcode_complete = 1'b1;
    tick();
    opcode_complete = 1'b0;
  endtask

  initial begin
    int early;
    int stable;
    rst = 1'b1;
    cmd_data = '0;
    cmd_valid = 1'b0;
    opcode_accept = 1'b0;
    opcode_complete = 1'b0;
    clear_errors = 1'b0;

    // Reset values
    #2;
    chk("rst_opcode", opcode, 64'd0);
    chk("rst_valid", 64'(opcode_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_issued", 64'(issued_count), 64'd0);
    chk("rst_completed", 64'(completed_count), 64'd0);
    chk("rst_errs", {62'd0, err_spurious, err_timeout}, 64'd0);
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Single opcode
    push(64'hA5);
    chk("single_valid_lat", 64'(opcode_valid), 64'd0);
    chk("single_busy", 64'(busy), 64'd1);
    tick();
    chk("single_valid", 64'(opcode_valid), 64'd1);
    chk("single_opcode", opcode, 64'hA5);
    tick();
    tick();
    chk("single_hold", 64'(opcode_valid), 64'd1);
    accept();
    chk("single_acc_valid", 64'(opcode_valid), 64'd0);
    chk("single_issued", 64'(issued_count), 64'd1);
    chk("single_cmp0", 64'(completed_count), 64'd0);
    tick();
    tick();
    complete();
    chk("single_completed", 64'(completed_count), 64'd1);
    chk("single_op_clr", opcode, 64'd0);
    chk("single_idle", 64'(busy), 64'd0);

    // Back-to-back, strictly one outstanding
    push(64'd1);
    push(64'd2);
    push(64'd3);
    for (int i = 1; i <= 3; i++) begin
      wait_valid(64'(i));
      accept();
      early = 0;
      repeat (3) begin
        tick();
        if (opcode_valid) early++;
      end
      chk("b2b_no_early", 64'(early), 64'd0);
      complete();
    end
    tick();
    chk("b2b_issued", 64'(issued_count), 64'd4);
    chk("b2b_completed", 64'(completed_count), 64'd4);
    chk("b2b_idle", 64'(busy), 64'd0);

    // FIFO full with the engine stalled: one in the opcode register, eight queued
    for (int i = 1; i <= 9; i++) push(64'h100 + 64'(i));
    chk("full_ready", 64'(cmd_ready), 64'd0);
    cmd_data  = 64'hDEAD;
    cmd_valid = 1'b1;
    repeat (5) tick();
    chk("full_held", 64'(cmd_ready), 64'd0);
    cmd_valid = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      wait_valid(64'h100 + 64'(i));
      accept();
      complete();
    end
    tick();
    tick();
    chk("full_drained", 64'(busy), 64'd0);
    chk("full_issued", 64'(issued_count), 64'd13);
    chk("full_completed", 64'(completed_count), 64'd13);

    // Stall for 50 cycles
    push(64'h55);
    wait_valid(64'h55);
    stable = 0;
    repeat (50) begin
      tick();
      if (opcode_valid && opcode == 64'h55 && issued_count == 16'd13) stable++;
    end
    chk("stall_stable", 64'(stable), 64'd50);
    accept();
    chk("stall_issued", 64'(issued_count), 64'd14);
    complete();
    chk("stall_completed", 64'(completed_count), 64'd14);

    // Protocol errors
    tick();
    complete();
    chk("sp_idle_cmp", 64'(err_spurious), 64'd1);
    chk("sp_issued", 64'(issued_count), 64'd14);
    chk("sp_completed", 64'(completed_count), 64'd14);
    clear_errors = 1'b1;
    tick();
    clear_errors = 1'b0;
    chk("sp_clear", 64'(err_spurious), 64'd0);
    clear_errors = 1'b1;
    opcode_complete = 1'b1;
    tick();
    clear_errors = 1'b0;
    opcode_complete = 1'b0;
    chk("sp_clear_prio", 64'(err_spurious), 64'd0);
    accept();
    chk("sp_idle_acc", 64'(err_spurious), 64'd1);
    chk("sp_acc_issued", 64'(issued_count), 64'd14);
    clear_errors = 1'b1;
    tick();
    clear_errors = 1'b0;
    push(64'h77);
    wait_valid(64'h77);
    opcode_accept = 1'b1;
    opcode_complete = 1'b1;
    tick();
    opcode_accept = 1'b0;
    opcode_complete = 1'b0;
    chk("same_issued", 64'(issued_count), 64'd15);
    chk("same_completed", 64'(completed_count), 64'd15);
    chk("same_valid", 64'(opcode_valid), 64'd0);
    chk("same_idle", 64'(busy), 64'd0);
    chk("same_no_err", 64'(err_spurious), 64'd0);
    push(64'h88);
    wait_valid(64'h88);
    accept();
    accept();
    chk("sp_wait_acc", 64'(err_spurious), 64'd1);
    chk("sp_wait_issued", 64'(issued_count), 64'd16);
    complete();
    chk("sp_wait_completed", 64'(completed_count), 64'd16);
    clear_errors = 1'b1;
    tick();
    clear_errors = 1'b0;

    // Timeout after 20 waiting cycles, then the next opcode issues
    push(64'hE1);
    push(64'hE2);
    wait_valid(64'hE1);
    accept();
    repeat (19) tick();
    chk("to_not_yet", 64'(err_timeout), 64'd0);
    tick();
    chk("to_fired", 64'(err_timeout), 64'd1);
    chk("to_completed", 64'(completed_count), 64'd16);
    chk("to_valid", 64'(opcode_valid), 64'd0);
    tick();
    chk("to_next_valid", 64'(opcode_valid), 64'd1);
    chk("to_next_op", opcode, 64'hE2);
    accept();
    chk("to_issued", 64'(issued_count), 64'd18);
    repeat (3) tick();

    // Asynchronous reset mid-wait
    #3;
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(opcode_valid), 64'd0);
    chk("arst_opcode", opcode, 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_issued", 64'(issued_count), 64'd0);
    chk("arst_completed", 64'(completed_count), 64'd0);
    chk("arst_errs", {62'd0, err_spurious, err_timeout}, 64'd0);
    chk("arst_ready", 64'(cmd_ready), 64'd1);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("arst_no_reissue", 64'(opcode_valid), 64'd0);
    chk("arst_idle", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
